// File: rtl/msg_streamer.sv
// Streams a stored message one character at a time to a busy/strobe transmitter.
// Messages start on request or from a free-running restart timer.
module msg_streamer #(
  parameter int DW             = 8,
  parameter int AW             = 4,
  parameter int RESTART_CLOCKS = 27_000_000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW:0]   i_len,
  input  logic          i_start,
  input  logic          i_auto,
  output logic          o_stb,
  output logic [DW-1:0] o_data,
  input  logic          i_busy,
  output logic          o_active,
  output logic          o_done
);

  localparam int            TW        = $clog2(RESTART_CLOCKS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(RESTART_CLOCKS - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [AW:0]   IDX_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_ev;

  logic [DW-1:0] mem [2**AW];

  // NOTE: the message buffer is deliberately not reset; a reset only aborts
  // the transfer, and the stored text must survive it.
  always_ff @(posedge i_clk) begin
    if (i_wr) mem[i_waddr] <= i_wdata;
  end

  assign timer_d  = (timer_q == '0) ? TIMER_MAX : timer_q - TIMER_ONE;
  assign start_ev = i_start || (i_auto && (timer_q == '0));

  // NOTE: every signal is given its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          if (i_len != '0) begin
            state_d = S_LOAD;
            idx_d   = '0;
            len_d   = i_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        data_d  = mem[idx_q[AW-1:0]];
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!i_busy) begin
          if (idx_q == len_q - IDX_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      timer_q <= TIMER_MAX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      done_q  <= done_d;
      timer_q <= timer_d;
    end
  end

  assign o_stb    = (state_q == S_SEND);
  assign o_active = (state_q != S_IDLE);
  assign o_data   = data_q;
  assign o_done   = done_q;

endmodule
